// File: rtl/addsub_pkg.sv
// Shared types for the add/subtract arbiter.
// FSM states, operation encodings and result flags.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/add_sub_logic.sv
// Combinational WIDTH-bit adder/subtractor with C/V/N/Z flags.
// Subtract is a + ~b + 1, so C=1 means no borrow.
module add_sub_logic #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] sum,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;

  assign bx   = op ? ~b : b;
  assign full = {1'b0, a} + {1'b0, bx}
              + {{WIDTH{1'b0}}, op};
  assign sum  = full[WIDTH-1:0];
  assign C    = full[WIDTH];
  assign V    = (a[WIDTH-1] == bx[WIDTH-1])
              && (sum[WIDTH-1] != a[WIDTH-1]);
  assign N    = sum[WIDTH-1];
  assign Z    = (sum == '0);

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter around one shared add/subtract unit.
// ADDSUB_ARB_RR_EN selects round-robin; default is fixed priority.
module addsub_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req0_op,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_c,
  output logic             rsp_v,
  output logic             rsp_n,
  output logic             rsp_z
);

  import addsub_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic             id_q;
  logic [WIDTH-1:0] sum_w;
  flags_t           flg_w;
  flags_t           flg_q;

`ifdef ADDSUB_ARB_RR_EN
  logic ptr;
`endif

  // rst_n gates the grant so ready stays low while in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
`ifdef ADDSUB_ARB_RR_EN
      if (!ptr) begin
        gnt0 = req0_valid;
        gnt1 = !req0_valid && req1_valid;
      end else begin
        gnt1 = req1_valid;
        gnt0 = !req1_valid && req0_valid;
      end
`else
      gnt0 = req0_valid;
      gnt1 = !req0_valid && req1_valid;
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (gnt0 || gnt1) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  add_sub_logic #(.WIDTH(WIDTH)) u_alu (
    .sum (sum_w),
    .C   (flg_w.c),
    .V   (flg_w.v),
    .N   (flg_w.n),
    .Z   (flg_w.z),
    .a   (a_q),
    .b   (b_q),
    .op  (op_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
      id_q <= 1'b0;
    end else begin
      unique case (1'b1)
        gnt0: begin
          a_q  <= req0_a;
          b_q  <= req0_b;
          op_q <= req0_op;
          id_q <= 1'b0;
        end
        gnt1: begin
          a_q  <= req1_a;
          b_q  <= req1_b;
          op_q <= req1_op;
          id_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      flg_q     <= '0;
    end else begin
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_sum   <= sum_w;
        flg_q     <= flg_w;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_c = flg_q.c;
  assign rsp_v = flg_q.v;
  assign rsp_n = flg_q.n;
  assign rsp_z = flg_q.z;

`ifdef ADDSUB_ARB_RR_EN
  // Prefer the requester that did not just win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (gnt0 || gnt1) begin
      ptr <= !gnt1;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed testbench for addsub_arbiter.
// Inputs change and outputs are sampled around the falling edge.
module tb_addsub_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req0_op;
  logic        req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_c;
  logic        rsp_v;
  logic        rsp_n;
  logic        rsp_z;

  int tests;
  int fails;

  addsub_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_c      (rsp_c),
    .rsp_v      (rsp_v),
    .rsp_n      (rsp_n),
    .rsp_z      (rsp_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {rsp_c, rsp_v, rsp_n, rsp_z};
  endfunction

  // One full transaction: accept, EXEC, RESP, handshake
  task automatic run_op(input string tag, input logic id,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] es,
                        input logic [3:0] ef);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    check({tag, "_rdy"}, id ? req1_ready : req0_ready, 1);
    check({tag, "_nrdy"}, id ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_v1"}, rsp_valid, 0);
    @(negedge clk);
    check({tag, "_v2"}, rsp_valid, 1);
    check({tag, "_sum"}, rsp_sum, es);
    check({tag, "_flg"}, flags(), ef);
    check({tag, "_id"}, rsp_id, id);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_done"}, rsp_valid, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       exp_ids [3];
    logic       ids [3];
    int         cnt;
    logic       seen1;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_op = 0; req1_op = 0;
    rsp_ready = 0;

    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_flags", flags(), 0);
    check("rst_id", rsp_id, 0);
    check("rst_rdy0", req0_ready, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1;

    // flags ordered {c,v,n,z}
    run_op("wrap",   0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0,         4'b1001);
    run_op("ovf",    1, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 4'b0110);
    run_op("borrow", 0, 32'h0,         32'h1, 1, 32'hFFFF_FFFF, 4'b0010);
    run_op("mixadd", 1, 32'h8000_0000, 32'h7FFF_FFFF, 0,
           32'hFFFF_FFFF, 4'b0010);
    run_op("sub53",  0, 32'h5, 32'h3, 1, 32'h2,          4'b1000);
    run_op("subovf", 1, 32'h8000_0000, 32'h1, 1,
           32'h7FFF_FFFF, 4'b1100);
    run_op("subz",   0, 32'h3, 32'h3, 1, 32'h0,          4'b1001);

    // Back-pressure with a pending second requester
    @(negedge clk);
    req0_valid = 1; req0_a = 2; req0_b = 3; req0_op = 0;
    #1 check("bp_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_a = 9; req1_b = 4; req1_op = 1;
    check("bp_exec_rdy1", req1_ready, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_v", rsp_valid, 1);
      check("bp_hold_sum", rsp_sum, 5);
      check("bp_hold_flg", flags(), 4'b0000);
      check("bp_hold_rdy", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_drop_v", rsp_valid, 0);
    check("bp_next_rdy1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    check("bp2_v", rsp_valid, 1);
    check("bp2_sum", rsp_sum, 5);
    check("bp2_flg", flags(), 4'b1000);
    check("bp2_id", rsp_id, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Both requesters valid continuously
    pulse_reset();
`ifdef ADDSUB_ARB_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0};
`endif
    req0_a = 1;  req0_b = 1; req0_op = 0;
    req1_a = 10; req1_b = 2; req1_op = 1;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    cnt = 0;
    seen1 = 1'b0;
    for (int cyc = 0; cyc < 30 && cnt < 3; cyc++) begin
      @(negedge clk);
      if (req1_ready) seen1 = 1'b1;
      if (rsp_valid) begin
        ids[cnt] = rsp_id;
        check("both_sum", rsp_sum, rsp_id ? 32'd8 : 32'd2);
        cnt++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    check("both_cnt", cnt, 3);
    for (int i = 0; i < 3; i++)
      if (i < cnt) check("both_id", ids[i], exp_ids[i]);
`ifndef ADDSUB_ARB_RR_EN
    check("fixed_no_rdy1", seen1, 0);
`endif
    @(negedge clk);
    rsp_ready = 0;

    // Reset while an operation is in EXEC
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h10; req0_b = 32'h20; req0_op = 0;
    #1 check("rx_rdy", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    rsp_ready = 1;
    #1 rst_n = 0;
    #1;
    check("rx_valid", rsp_valid, 0);
    check("rx_sum", rsp_sum, 0);
    @(negedge clk);
    rst_n = 1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("rx_no_rsp", cnt, 0);
    rsp_ready = 0;
    run_op("post_rst", 0, 32'h10, 32'h20, 0, 32'h30, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester operation valid.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-007 SHALL have ports req0_op/req1_op  input  1  0 = add, 1 = subtract (a-b).
REQ-008 SHALL have port rsp_valid  output  1  result valid.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  1  requester index owning result.
REQ-011 SHALL have port rsp_sum  output  WIDTH  result.
REQ-012 SHALL have ports rsp_c, rsp_v, rsp_n, rsp_z  output  1  carry, signed overflow, negative, zero.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at most.
REQ-014 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally that cycle, register a/b/op/id, go EXEC; else stay IDLE.
REQ-015 reqN_ready SHALL be 0 outside IDLE and for the non-granted requester.
REQ-016 EXEC: SHALL compute result from registered operands, register sum and flags into rsp_* , set rsp_valid, go RESP.
REQ-017 RESP: SHALL hold all rsp_* stable while rsp_valid && !rsp_ready; on rsp_valid && rsp_ready SHALL clear rsp_valid and go IDLE.
REQ-018 Latency: rsp_valid SHALL rise 2 cycles after the accepting edge; minimum initiation interval 3 cycles.
REQ-019 Arithmetic: add = a+b mod 2^WIDTH; sub = a + ~b + 1 mod 2^WIDTH.
REQ-020 rsp_c SHALL be carry-out of the WIDTH-bit sum (sub: 1 = no borrow); rsp_v SHALL be signed overflow; rsp_n SHALL be sum MSB; rsp_z SHALL be 1 iff sum == 0.
REQ-021 Requesters SHALL hold operands stable while valid && !ready; arbiter samples only on accept.
REQ-022 Simultaneous valid: winner per REQ-030; loser stays pending, granted on next IDLE visit.

Reset
REQ-023 rst_n low SHALL force IDLE, rsp_valid=0, rsp_id=0, rsp_sum=0, all flags 0, rr pointer=0, both reqN_ready=0, asynchronously.
REQ-024 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.
REQ-025 Deassertion SHALL be synchronous to clk; first grant possible on the first edge after release.

Configuration
REQ-026 Macro ADDSUB_ARB_RR_EN SHALL select arbitration policy.
REQ-027 Defined: round-robin; pointer indicates preferred requester, toggles to the other after each grant.
REQ-028 Undefined: fixed priority, requester 0 always wins; pointer logic absent.
REQ-029 Interface and timing SHALL be identical in both builds.
REQ-030 Winner = preferred requester if valid, else the other (RR); requester 0 if valid, else 1 (fixed).

Structure
REQ-031 Shared package addsub_pkg SHALL hold FSM state enum, OP_ADD/OP_SUB encodings, flags struct {c,v,n,z}.
REQ-032 SHALL instantiate existing add_sub_logic (sum,C,V,N,Z,a,b,op) as sole sub-module, fed from operand registers.

Verification
REQ-033 req0 FFFF_FFFF+0000_0001 add -> rsp_sum 0, C1 V0 N0 Z1, id0, rsp_valid 2 cycles after accept.
REQ-034 req1 7FFF_FFFF+0000_0001 add -> 8000_0000, C0 V1 N1 Z0, id1.
REQ-035 req0 0000_0000-0000_0001 sub -> FFFF_FFFF, C0 V0 N1 Z0; 8000_0000+7FFF_FFFF add -> FFFF_FFFF, V0 N1.
REQ-036 Both valid continuously, RR build -> ids 0,1,0,1; fixed build -> ids 0,0,0; req1 never ready.
REQ-037 rsp_ready low 5 cycles -> rsp_* stable, no reqN_ready; raise -> handshake, next grant following cycle.
REQ-038 rst_n low during EXEC -> rsp_valid 0 immediately, no response after release, new request accepted normally.
